// File: rtl/program_loader.sv
// Boot loader: parses a byte stream into 32-bit IMEM/DMEM writes and releases CPU start on a START command.
// Latency: write strobe is high the cycle after the 4th data byte transfers; start_o rises the cycle after START.
// Backpressure: rx_ready_o is high in every state except RUN, so bytes can arrive one per cycle without bubbles.
module program_loader #(
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 5
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               rx_valid_i,
   input  logic [7:0]         rx_data_i,
   output logic               rx_ready_o,
   output logic               imem_we_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic [31:0]        imem_data_o,
   output logic               dmem_we_o,
   output logic [DMEM_AW-1:0] dmem_addr_o,
   output logic [31:0]        dmem_data_o,
   output logic               start_o,
   output logic               err_o,
   output logic [15:0]        words_o
);

   // The address register is at least a byte wide so the ADDR byte is never truncated before wrapping.
   localparam int AQW = (IMEM_AW > 8) ? IMEM_AW : 8;

   typedef enum logic [2:0] {S_CMD, S_ADDR, S_COUNT, S_DATA, S_RUN} state_t;

   state_t             state_q;
   logic               tgt_d_q;      // 1: current frame targets DMEM
   logic [AQW-1:0]     addr_q;
   logic [8:0]         cnt_q;        // words remaining, 1..256
   logic [1:0]         bidx_q;
   logic [23:0]        word_q;       // low three bytes of the word being assembled
   logic               rdy_q;
   logic               imem_we_q;
   logic [IMEM_AW-1:0] imem_addr_q;
   logic [31:0]        imem_data_q;
   logic               dmem_we_q;
   logic [DMEM_AW-1:0] dmem_addr_q;
   logic [31:0]        dmem_data_q;
   logic               start_q;
   logic               err_q;
   logic [15:0]        words_q;

   logic               xfer;
   logic [31:0]        word_d;
   logic [AQW-1:0]     addr_d;

   assign xfer   = rx_valid_i & rdy_q;
   assign word_d = {rx_data_i, word_q};
   assign addr_d = AQW'(rx_data_i);

   // Frame parser, word assembly and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_CMD;
         tgt_d_q     <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         bidx_q      <= '0;
         word_q      <= '0;
         rdy_q       <= 1'b1;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         dmem_we_q   <= 1'b0;
         dmem_addr_q <= '0;
         dmem_data_q <= '0;
         start_q     <= 1'b0;
         err_q       <= 1'b0;
         words_q     <= '0;
      end else begin
         // Strobes are single-cycle pulses unless re-armed below.
         imem_we_q <= 1'b0;
         dmem_we_q <= 1'b0;
         if (xfer) begin
            case (state_q)
               S_CMD: begin
                  if (rx_data_i == 8'h01 || rx_data_i == 8'h02) begin
                     tgt_d_q <= (rx_data_i == 8'h02);
                     state_q <= S_ADDR;
                  end else if (rx_data_i == 8'h03) begin
                     state_q <= S_RUN;
                     rdy_q   <= 1'b0;
                     start_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               S_ADDR: begin
                  addr_q  <= addr_d;
                  state_q <= S_COUNT;
               end
               S_COUNT: begin
                  cnt_q   <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
                  bidx_q  <= 2'd0;
                  state_q <= S_DATA;
               end
               S_DATA: begin
                  case (bidx_q)
                     2'd0: word_q[7:0]   <= rx_data_i;
                     2'd1: word_q[15:8]  <= rx_data_i;
                     2'd2: word_q[23:16] <= rx_data_i;
                     default: begin
                        // Fourth byte: emit the word and advance to the next slot.
                        if (tgt_d_q) begin
                           dmem_we_q   <= 1'b1;
                           dmem_addr_q <= {addr_q[DMEM_AW-3:0], 2'b00};
                           dmem_data_q <= word_d;
                        end else begin
                           imem_we_q   <= 1'b1;
                           imem_addr_q <= addr_q[IMEM_AW-1:0];
                           imem_data_q <= word_d;
                        end
                        if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
                        addr_q <= addr_q + AQW'(1);
                        cnt_q  <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) state_q <= S_CMD;
                     end
                  endcase
                  bidx_q <= bidx_q + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready_o  = rdy_q;
   assign imem_we_o   = imem_we_q;
   assign imem_addr_o = imem_addr_q;
   assign imem_data_o = imem_data_q;
   assign dmem_we_o   = dmem_we_q;
   assign dmem_addr_o = dmem_addr_q;
   assign dmem_data_o = dmem_data_q;
   assign start_o     = start_q;
   assign err_o       = err_q;
   assign words_o     = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes are queued as bytes are sent and popped on each strobe.
// Strobe cycle is checked 1 time unit after the 4th-byte edge; all other sampling is on the falling edge.
// Byte sender waits a bounded number of cycles for rx_ready_o and reports a timeout as a failure.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready_o;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        dmem_we_o;
   logic [4:0]  dmem_addr_o;
   logic [31:0] dmem_data_o;
   logic        start_o;
   logic        err_o;
   logic [15:0] words_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          d;
      logic [7:0]  a;
      logic [31:0] w;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pay[$];
   int          exp_words = 0;

   program_loader #(.IMEM_AW(8), .DMEM_AW(5)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .rx_valid_i (rx_valid),
      .rx_data_i  (rx_data),
      .rx_ready_o (rx_ready_o),
      .imem_we_o  (imem_we_o),
      .imem_addr_o(imem_addr_o),
      .imem_data_o(imem_data_o),
      .dmem_we_o  (dmem_we_o),
      .dmem_addr_o(dmem_addr_o),
      .dmem_data_o(dmem_data_o),
      .start_o    (start_o),
      .err_o      (err_o),
      .words_o    (words_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe must match the oldest queued write.
   always @(negedge clk) begin
      if (imem_we_o === 1'b1 || dmem_we_o === 1'b1) begin
         exp_t e;
         chk("one_strobe", {31'd0, imem_we_o & dmem_we_o}, 32'd0);
         chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_target", {31'd0, dmem_we_o}, {31'd0, e.d});
            if (e.d) begin
               chk("dmem_addr", {27'd0, dmem_addr_o}, {24'd0, e.a});
               chk("dmem_data", dmem_data_o, e.w);
            end else begin
               chk("imem_addr", {24'd0, imem_addr_o}, {24'd0, e.a});
               chk("imem_data", imem_data_o, e.w);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 20 && !rx_ready_o; t++) @(negedge clk);
      if (!rx_ready_o) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed=ready0 expected=ready1 byte=%h", b);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   // Sends a LOAD frame carrying the words in pay and queues the expected writes.
   task automatic frame(input bit d, input logic [7:0] a, input int maxgap);
      int          n;
      logic [7:0]  idx;
      logic [31:0] w;
      exp_t        e;
      n = pay.size();
      send(d ? 8'h02 : 8'h01, $urandom_range(0, maxgap));
      send(a, $urandom_range(0, maxgap));
      send(n[7:0], $urandom_range(0, maxgap));
      for (int i = 0; i < n; i++) begin
         idx = a + i[7:0];
         w   = pay[i];
         e.d = d;
         e.a = d ? {3'd0, idx[2:0], 2'b00} : idx;
         e.w = w;
         sb.push_back(e);
         if (exp_words < 16'hFFFF) exp_words++;
         for (int k = 0; k < 4; k++) send(w[8*k +: 8], $urandom_range(0, maxgap));
         #1;
         chk("wr_latency", {31'd0, d ? dmem_we_o : imem_we_o}, 32'd1);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      chk("rst_ready", {31'd0, rx_ready_o}, 32'd1);
      chk("rst_imem_we", {31'd0, imem_we_o}, 32'd0);
      chk("rst_dmem_we", {31'd0, dmem_we_o}, 32'd0);
      chk("rst_start", {31'd0, start_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_words", {16'd0, words_o}, 32'd0);
      chk("rst_imem_data", imem_data_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two IMEM words at index 0.
      pay = '{32'h00500013, 32'h00B50133};
      frame(1'b0, 8'h00, 0);
      idle(2);
      chk("t1_words", {16'd0, words_o}, 32'd2);
      chk("t1_sb_empty", sb.size(), 32'd0);

      // DMEM index 7 and index 15 (upper bit ignored) both land at byte 0x1C.
      pay = '{32'h00000005};
      frame(1'b1, 8'h07, 0);
      idle(2);
      chk("t2_dmem_addr7", {27'd0, dmem_addr_o}, 32'h1C);
      pay = '{32'h0000A5A5};
      frame(1'b1, 8'h0F, 0);
      idle(2);
      chk("t2_dmem_addr15", {27'd0, dmem_addr_o}, 32'h1C);
      chk("t2_words", {16'd0, words_o}, exp_words);

      // IMEM index wrap 0xFF -> 0x00, then a 256-word frame via count byte 0.
      pay = '{32'h11223344, 32'h55667788};
      frame(1'b0, 8'hFF, 0);
      idle(2);
      chk("t3_wrap_addr", {24'd0, imem_addr_o}, 32'h00);
      pay = {};
      for (int i = 0; i < 256; i++) pay.push_back(32'(i) * 32'h9E3779B9 + 32'h1234);
      frame(1'b0, 8'h80, 0);
      idle(2);
      chk("t3_256_words", {16'd0, words_o}, exp_words);
      chk("t3_sb_empty", sb.size(), 32'd0);

      // Three IMEM words with random idle gaps between bytes.
      pay = '{32'hDEADBEEF, 32'h0BADF00D, 32'hFEEDFACE};
      frame(1'b0, 8'h20, 3);
      idle(2);
      chk("t4_words", {16'd0, words_o}, exp_words);
      chk("t4_sb_empty", sb.size(), 32'd0);

      // Bad command sets sticky err; a following valid frame still loads.
      send(8'h7E, 0);
      idle(1);
      chk("t5_err_set", {31'd0, err_o}, 32'd1);
      chk("t5_ready_after_err", {31'd0, rx_ready_o}, 32'd1);
      pay = '{32'hC0FFEE00};
      frame(1'b1, 8'h02, 0);
      idle(2);
      chk("t5_err_sticky", {31'd0, err_o}, 32'd1);
      chk("t5_words", {16'd0, words_o}, exp_words);

      // START: start_o high and rx_ready_o low the next cycle; later bytes refused.
      send(8'h03, 0);
      @(negedge clk);
      chk("t6_start", {31'd0, start_o}, 32'd1);
      chk("t6_ready_low", {31'd0, rx_ready_o}, 32'd0);
      rx_valid = 1'b1;
      rx_data  = 8'h01;
      repeat (6) @(negedge clk);
      chk("t6_still_not_ready", {31'd0, rx_ready_o}, 32'd0);
      chk("t6_still_start", {31'd0, start_o}, 32'd1);
      chk("t6_err_still", {31'd0, err_o}, 32'd1);
      chk("t6_words_frozen", {16'd0, words_o}, exp_words);
      chk("t6_sb_empty", sb.size(), 32'd0);

      // Asynchronous reset mid-cycle drops start_o and clears counters at once.
      #3;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      exp_words = 0;
      #1;
      chk("t7_start_drop", {31'd0, start_o}, 32'd0);
      chk("t7_words_clr", {16'd0, words_o}, 32'd0);
      chk("t7_err_clr", {31'd0, err_o}, 32'd0);
      chk("t7_ready", {31'd0, rx_ready_o}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Partial word interrupted by reset produces no strobe.
      send(8'h01, 0);
      send(8'h10, 0);
      send(8'h01, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      #2;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      #1;
      chk("t8_no_strobe", {31'd0, imem_we_o}, 32'd0);
      chk("t8_words_clr", {16'd0, words_o}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("t8_words_idle", {16'd0, words_o}, 32'd0);
      pay = '{32'hCAFEF00D};
      frame(1'b0, 8'h10, 0);
      idle(2);
      chk("t8_new_frame_addr", {24'd0, imem_addr_o}, 32'h10);
      chk("t8_words", {16'd0, words_o}, 32'd1);
      chk("t8_sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
